// File: rtl/act_lut_loader_pkg.sv
// Shared constants for the activation LUT loader.
//   - State encoding (IDLE, LOAD, CHECK, READY) as legacy-compatible constants.
//   - Default table geometry (ADDR_W, DATA_W) and the entry count.
package act_lut_loader_pkg;

  localparam int unsigned LUT_ADDR_W  = 4;
  localparam int unsigned LUT_DATA_W  = 8;
  localparam int unsigned LUT_ENTRIES = 1 << LUT_ADDR_W;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_LOAD  = 2'd1;
  localparam logic [STATE_W-1:0] ST_CHECK = 2'd2;
  localparam logic [STATE_W-1:0] ST_READY = 2'd3;

endpackage : act_lut_loader_pkg

// File: rtl/act_lut_regfile.sv
// Activation table storage: one synchronous write port and a combinational
// dual read port returning entry[a] and entry[a+1], the latter saturating at
// the last entry so the top segment has zero slope.
// Ports:
//   clk_i, rst_i          clock, async active-high reset (clears all entries)
//   we_i, waddr_i, wdata_i  write port
//   raddr_i               read address
//   rbase_o, rnext_o      entry[raddr], entry[min(raddr+1, last)]
module act_lut_regfile #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rbase_o,
  output logic [DATA_W-1:0] rnext_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [ADDR_W-1:0] raddr_next;

  // Storage array, cleared to zero on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Next address saturates at the last entry.
  always_comb begin
    raddr_next = raddr_i + ADDR_W'(1);
    if (raddr_i == '1) begin
      raddr_next = raddr_i;
    end
  end

  assign rbase_o = mem_q[raddr_i];
  assign rnext_o = mem_q[raddr_next];

endmodule : act_lut_regfile

// File: rtl/act_lut_loader.sv
// Writable activation lookup table with a streaming valid/ready load port.
// Sixteen signed samples are streamed in after load_start; the table then
// serves base/next pairs combinationally to the activation interpolator.
// Optional feature: define ACT_LUT_CHECKSUM_EN to add a 17th checksum beat
// (modulo-2^DATA_W sum of the samples) checked in a CHECK state; err is live
// only in that build and tied to 0 otherwise.
// Ports:
//   clk, rst                     clock, async active-high reset
//   load_start                   begin / restart a table load
//   wr_valid, wr_data, wr_ready  load beat handshake
//   busy, loaded, err            load status
//   rd_address                   segment index
//   rd_base, rd_next_data        entry[a], entry[min(a+1, last)]
module act_lut_loader
  import act_lut_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = LUT_ADDR_W,
  parameter int unsigned DATA_W = LUT_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     wr_valid,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic                     wr_ready,
  output logic                     busy,
  output logic                     loaded,
  output logic                     err,
  input  logic        [ADDR_W-1:0] rd_address,
  output logic signed [DATA_W-1:0] rd_base,
  output logic signed [DATA_W-1:0] rd_next_data
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic               loaded_q, loaded_d;
  logic               wr_en_c;
  logic               accept_c;

`ifdef ACT_LUT_CHECKSUM_EN
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               err_q, err_d;
`endif

  // A beat is taken only when no restart is requested in the same cycle.
  assign accept_c = wr_valid && wr_ready && !load_start;

  // State, counter and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      loaded_q <= 1'b0;
`ifdef ACT_LUT_CHECKSUM_EN
      acc_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
`ifdef ACT_LUT_CHECKSUM_EN
      acc_q    <= acc_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and write-enable logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    wr_en_c  = 1'b0;
`ifdef ACT_LUT_CHECKSUM_EN
    acc_d    = acc_q;
    err_d    = err_q;
`endif

    case (state_q)
      ST_IDLE, ST_READY: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          count_d  = '0;
          loaded_d = 1'b0;
`ifdef ACT_LUT_CHECKSUM_EN
          acc_d    = '0;
          err_d    = 1'b0;
`endif
        end
      end

      ST_LOAD: begin
        if (load_start) begin
          count_d = '0;
`ifdef ACT_LUT_CHECKSUM_EN
          acc_d   = '0;
`endif
        end else if (accept_c) begin
          wr_en_c = 1'b1;
          count_d = count_q + ADDR_W'(1);
`ifdef ACT_LUT_CHECKSUM_EN
          acc_d   = acc_q + DATA_W'(wr_data);
`endif
          if (count_q == '1) begin
`ifdef ACT_LUT_CHECKSUM_EN
            state_d  = ST_CHECK;
`else
            state_d  = ST_READY;
            loaded_d = 1'b1;
`endif
          end
        end
      end

`ifdef ACT_LUT_CHECKSUM_EN
      ST_CHECK: begin
        if (load_start) begin
          state_d = ST_LOAD;
          count_d = '0;
          acc_d   = '0;
        end else if (accept_c) begin
          if (DATA_W'(wr_data) == acc_q) begin
            state_d  = ST_READY;
            loaded_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            loaded_d = 1'b0;
            err_d    = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decode directly from registered state.
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign wr_ready = busy;
  assign loaded   = loaded_q;
`ifdef ACT_LUT_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

  logic [DATA_W-1:0] rbase_c, rnext_c;

  act_lut_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_en_c),
    .waddr_i (count_q),
    .wdata_i (wr_data),
    .raddr_i (rd_address),
    .rbase_o (rbase_c),
    .rnext_o (rnext_c)
  );

  assign rd_base      = rbase_c;
  assign rd_next_data = rnext_c;

endmodule : act_lut_loader
